hpm_counter_bank: RTL and testbench

//  Parametrised bank of NUM_CNT hardware performance counters, each CNT_WIDTH bits wide.
//  - Each counter counts one selectable event from NUM_EVT per-cycle event strobes.
//  - Generalises the fixed mcycle/minstret pair into programmable counters.
//  - Exposes event-select registers, a global inhibit mask and overflow tracking.
//  - Sits beside the CSR unit, which decodes CSR addresses into s_csr_idx_i / s_csr_sel_i.

---
 rtl/hpm_counter_bank.sv | 143 ++++++++++++++
 tb/tb_hpm_counter_bank.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/hpm_counter_bank.sv
// rtl/hpm_counter_bank.sv - programmable HPM counter bank with CSR access
// Optional overflow tracking and interrupt enabled by defining HPM_OVF_IRQ_EN.
module hpm_counter_bank #(
  parameter int NUM_CNT   = 4,
  parameter int CNT_WIDTH = 64,
  parameter int NUM_EVT   = 16,
  parameter int IDX_W     = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1,
  parameter int EVSEL_W   = 8
) (
  input  logic               s_clk_i,
  input  logic               s_reset_i,
  input  logic [NUM_EVT-1:0] s_event_i,
  input  logic               s_csr_re_i,
  input  logic               s_csr_we_i,
  input  logic [IDX_W-1:0]   s_csr_idx_i,
  input  logic [1:0]         s_csr_sel_i,
  input  logic [31:0]        s_csr_wdata_i,
  output logic [31:0]        s_csr_rdata_o,
  output logic               s_csr_rvalid_o,
  output logic               s_ovf_irq_o
);

  localparam int HI_W = CNT_WIDTH - 32;

  logic [CNT_WIDTH-1:0] r_cnt   [NUM_CNT];
  logic [EVSEL_W-1:0]   r_evsel [NUM_CNT];
  logic [NUM_CNT-1:0]   r_inhibit;
  logic [NUM_CNT-1:0]   w_inc;
  logic [NUM_CNT-1:0]   w_ovf;
  logic                 w_idx_ok;
  logic                 w_wr_glb;
  logic [31:0]          w_rd_data;
  logic [31:0]          r_rdata;
  logic                 r_rvalid;

  assign w_idx_ok = (int'(s_csr_idx_i) < NUM_CNT);
  assign w_wr_glb = s_csr_we_i && (s_csr_sel_i == 2'd3);

  genvar g;
  for (g = 0; g < NUM_CNT; g++) begin : g_cnt
    logic w_evt_hit;
    logic w_sel_me;
    logic w_wr_lo;
    logic w_wr_hi;
    logic w_wr_ev;

    // Scan the event list rather than index it, so evsel values past NUM_EVT simply never match.
    always_comb begin
      w_evt_hit = 1'b0;
      for (int e = 0; e < NUM_EVT; e++) begin
        if (int'(r_evsel[g]) == e + 1) w_evt_hit = s_event_i[e];
      end
    end

    assign w_sel_me = s_csr_we_i && w_idx_ok && (int'(s_csr_idx_i) == g);
    assign w_wr_lo  = w_sel_me && (s_csr_sel_i == 2'd0);
    assign w_wr_hi  = w_sel_me && (s_csr_sel_i == 2'd1);
    assign w_wr_ev  = w_sel_me && (s_csr_sel_i == 2'd2);
    assign w_inc[g] = !r_inhibit[g] && w_evt_hit && !w_wr_lo && !w_wr_hi;

    always_ff @(posedge s_clk_i or posedge s_reset_i) begin
      if (s_reset_i) begin
        r_cnt[g]   <= '0;
        r_evsel[g] <= '0;
      end else begin
        if (w_wr_lo) begin
          r_cnt[g][31:0] <= s_csr_wdata_i;
        end else if (w_wr_hi) begin
          r_cnt[g][CNT_WIDTH-1:32] <= s_csr_wdata_i[HI_W-1:0];
        end else if (w_inc[g]) begin
          r_cnt[g] <= r_cnt[g] + CNT_WIDTH'(1);
        end
        if (w_wr_ev) r_evsel[g] <= s_csr_wdata_i[EVSEL_W-1:0];
      end
    end
  end

  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      r_inhibit <= '0;
    end else if (w_wr_glb) begin
      r_inhibit <= s_csr_wdata_i[NUM_CNT-1:0];
    end
  end

`ifdef HPM_OVF_IRQ_EN
  logic [NUM_CNT-1:0] r_ovf;
  logic [NUM_CNT-1:0] w_wrap;
  logic [NUM_CNT-1:0] w_ovf_clr;
  logic               r_irq;

  for (g = 0; g < NUM_CNT; g++) begin : g_wrap
    assign w_wrap[g] = w_inc[g] && (&r_cnt[g]);
  end

  assign w_ovf_clr = w_wr_glb ? s_csr_wdata_i[16+:NUM_CNT] : '0;

  // Set has priority over a simultaneous write-1-to-clear.
  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      r_ovf <= '0;
      r_irq <= 1'b0;
    end else begin
      r_ovf <= (r_ovf & ~w_ovf_clr) | w_wrap;
      r_irq <= |r_ovf;
    end
  end

  assign w_ovf       = r_ovf;
  assign s_ovf_irq_o = r_irq;
`else
  assign w_ovf       = '0;
  assign s_ovf_irq_o = 1'b0;
`endif

  always_comb begin
    w_rd_data = '0;
    case (s_csr_sel_i)
      2'd0: if (w_idx_ok) w_rd_data = r_cnt[s_csr_idx_i][31:0];
      2'd1: if (w_idx_ok) w_rd_data[HI_W-1:0] = r_cnt[s_csr_idx_i][CNT_WIDTH-1:32];
      2'd2: if (w_idx_ok) w_rd_data[EVSEL_W-1:0] = r_evsel[s_csr_idx_i];
      default: begin
        w_rd_data[0+:NUM_CNT]  = r_inhibit;
        w_rd_data[16+:NUM_CNT] = w_ovf;
      end
    endcase
  end

  // Read data is captured from pre-edge state, so a coincident write is not visible.
  always_ff @(posedge s_clk_i or posedge s_reset_i) begin
    if (s_reset_i) begin
      r_rdata  <= '0;
      r_rvalid <= 1'b0;
    end else begin
      r_rvalid <= s_csr_re_i;
      if (s_csr_re_i) r_rdata <= w_rd_data;
    end
  end

  assign s_csr_rdata_o  = r_rdata;
  assign s_csr_rvalid_o = r_rvalid;

endmodule

// File: tb/tb_hpm_counter_bank.sv
// tb/tb_hpm_counter_bank.sv - scoreboard bench for hpm_counter_bank
// Build with HPM_OVF_IRQ_EN to exercise the overflow interrupt expectations.
module tb_hpm_counter_bank;

`ifdef HPM_OVF_IRQ_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] events;
  logic        re;
  logic        we;
  logic [1:0]  idx;
  logic [1:0]  sel;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rvalid;
  logic        irq;
  logic        re_q;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  hpm_counter_bank dut (
    .s_clk_i       (clk),
    .s_reset_i     (rst),
    .s_event_i     (events),
    .s_csr_re_i    (re),
    .s_csr_we_i    (we),
    .s_csr_idx_i   (idx),
    .s_csr_sel_i   (sel),
    .s_csr_wdata_i (wdata),
    .s_csr_rdata_o (rdata),
    .s_csr_rvalid_o(rvalid),
    .s_ovf_irq_o   (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) re_q <= 1'b0;
    else     re_q <= re;
  end

  // rvalid must follow re by exactly one cycle; each valid pops one expectation.
  always @(negedge clk) begin
    if (!rst) begin
      chk("rvalid", {63'd0, rvalid}, {63'd0, re_q});
      if (rvalid) begin
        if (exp_q.size() == 0) chk("sb_underflow", 64'(exp_q.size()), 64'd1);
        else chk("rdata", {32'd0, rdata}, {32'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [1:0] i, input logic [1:0] s, input logic [31:0] d);
    we = 1'b1; idx = i; sel = s; wdata = d;
    step();
    we = 1'b0;
  endtask

  task automatic csr_rd(input logic [1:0] i, input logic [1:0] s, input logic [31:0] e);
    re = 1'b1; idx = i; sel = s;
    exp_q.push_back(e);
    step();
    re = 1'b0;
  endtask

  task automatic csr_wr_rd(input logic [1:0] i, input logic [31:0] d, input logic [31:0] e);
    we = 1'b1; re = 1'b1; idx = i; sel = 2'd0; wdata = d;
    exp_q.push_back(e);
    step();
    we = 1'b0; re = 1'b0;
  endtask

  initial begin
    rst = 1'b1; events = '0; re = 1'b0; we = 1'b0; idx = '0; sel = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();
    chk("reset_rvalid", {63'd0, rvalid}, 64'd0);
    chk("reset_rdata", {32'd0, rdata}, 64'd0);
    chk("reset_irq", {63'd0, irq}, 64'd0);

    // evsel = 0 everywhere: all-ones events must not count
    events = 16'hFFFF;
    repeat (10) step();
    for (int i = 0; i < 4; i++) begin
      csr_rd(2'(i), 2'd0, 32'd0);
      csr_rd(2'(i), 2'd1, 32'd0);
    end
    events = '0;

    csr_wr(2'd1, 2'd2, 32'd3);
    csr_rd(2'd1, 2'd2, 32'd3);
    events = 16'h0004;
    repeat (5) step();
    events = '0;
    csr_rd(2'd1, 2'd0, 32'd5);

    // Carry from the low half into the high half
    csr_wr(2'd0, 2'd0, 32'hFFFF_FFFF);
    csr_wr(2'd0, 2'd2, 32'd1);
    events = 16'h0001;
    step();
    events = '0;
    csr_rd(2'd0, 2'd0, 32'd0);
    csr_rd(2'd0, 2'd1, 32'd1);

    // Write wins over increment; coincident read returns pre-write value
    csr_wr(2'd2, 2'd2, 32'd5);
    events = 16'h0010;
    repeat (3) step();
    csr_wr_rd(2'd2, 32'd100, 32'd3);
    csr_rd(2'd2, 2'd0, 32'd100);
    csr_rd(2'd2, 2'd0, 32'd101);
    events = '0;
    csr_rd(2'd2, 2'd0, 32'd102);

    // Inhibit freezes counter 3 only
    csr_wr(2'd3, 2'd2, 32'd6);
    events = 16'hFFFF;
    repeat (2) step();
    csr_wr(2'd0, 2'd3, 32'h0000_0008);
    repeat (4) step();
    csr_wr(2'd0, 2'd3, 32'h0000_0000);
    repeat (2) step();
    events = '0;
    csr_rd(2'd0, 2'd0, 32'd10);
    csr_rd(2'd0, 2'd1, 32'd1);
    csr_rd(2'd1, 2'd0, 32'd15);
    csr_rd(2'd2, 2'd0, 32'd112);
    csr_rd(2'd3, 2'd0, 32'd5);
    csr_rd(2'd0, 2'd3, 32'd0);
    csr_wr(2'd0, 2'd3, 32'h0000_0005);
    csr_rd(2'd2, 2'd3, 32'h0000_0005);
    csr_wr(2'd0, 2'd3, 32'h0000_0000);

    // Full wrap of counter 0
    csr_wr(2'd0, 2'd1, 32'hFFFF_FFFF);
    csr_wr(2'd0, 2'd0, 32'hFFFF_FFFF);
    events = 16'h0001;
    step();
    events = '0;
    chk("irq_not_yet", {63'd0, irq}, 64'd0);
    csr_rd(2'd0, 2'd0, 32'd0);
    chk("irq_after_wrap", {63'd0, irq}, {63'd0, OVF_EN});
    csr_rd(2'd0, 2'd1, 32'd0);
    csr_rd(2'd0, 2'd3, OVF_EN ? 32'h0001_0000 : 32'd0);
    csr_wr(2'd0, 2'd3, 32'h0001_0000);
    csr_rd(2'd0, 2'd3, 32'd0);
    chk("irq_cleared", {63'd0, irq}, 64'd0);

    // Writing zero directly is not an overflow
    csr_wr(2'd1, 2'd0, 32'd0);
    repeat (2) step();
    chk("irq_zero_write", {63'd0, irq}, 64'd0);

    repeat (2) step();
    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
